// File: rtl/demux_deser_pkg.sv
// rtl/demux_deser_pkg.sv - shared lane types and frame sizing for the demux lane deserializer
// DEMUX_DESER_PARITY_EN adds one trailing even-parity bit to every frame.
package demux_deser_pkg;

  localparam int LANES = 4;

  typedef logic [1:0] lane_idx_t;

`ifdef DEMUX_DESER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int frame_bits(input int data_w);
    return PARITY_EN ? data_w + 1 : data_w;
  endfunction

  localparam int FRAME_BITS = frame_bits(8);

endpackage

// File: rtl/demux_deser_lane.sv
// rtl/demux_deser_lane.sv - one lane: shift register, bit counter, single-frame hold, overflow, parity
// DEMUX_DESER_PARITY_EN selects parity checking of the received frame.
module demux_deser_lane
  import demux_deser_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              bit_in,
  input  logic              drain,
  input  logic              ovf_clr,
  output logic              hold_full,
  output logic [DATA_W-1:0] hold_data,
  output logic              hold_perr,
  output logic              ovf
);

  localparam int FB = frame_bits(DATA_W);
  localparam int CW = $clog2(FB + 1);

  logic [FB-1:0]     sr;
  logic [CW-1:0]     cnt;
  logic [FB-1:0]     frame;
  logic [DATA_W-1:0] frame_data;
  logic              frame_perr;
  logic              complete;
  logic              overflow;

  assign frame    = {sr[FB-2:0], bit_in};
  assign complete = shift_en && !clr && (cnt == CW'(FB - 1));
  assign overflow = complete && hold_full && !drain;

`ifdef DEMUX_DESER_PARITY_EN
  assign frame_data = frame[FB-1:1];
  assign frame_perr = ^frame;
`else
  assign frame_data = frame;
  assign frame_perr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_perr <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (clr) begin
        sr  <= '0;
        cnt <= '0;
      end else if (shift_en) begin
        if (complete) begin
          sr  <= '0;
          cnt <= '0;
        end else begin
          sr  <= frame;
          cnt <= cnt + CW'(1);
        end
      end

      // A drain on the same edge frees the slot for the incoming frame.
      if (complete && (!hold_full || drain)) begin
        hold_full <= 1'b1;
        hold_data <= frame_data;
        hold_perr <= frame_perr;
      end else if (drain) begin
        hold_full <= 1'b0;
      end

      if (ovf_clr) begin
        ovf <= 1'b0;
      end else if (overflow) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_lane_deserializer.sv
// rtl/demux_lane_deserializer.sv - steers demux lane bits into four deserializers and merges frames round-robin
// DEMUX_DESER_PARITY_EN enables per-frame parity; otherwise out_perr stays 0.
module demux_lane_deserializer
  import demux_deser_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_vld,
  input  logic [1:0]        sel,
  input  logic              y0,
  input  logic              y1,
  input  logic              y2,
  input  logic              y3,
  input  logic              clr,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_lane,
  output logic              out_perr,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [3:0]        ovf,
  input  logic              ovf_clr
);

  logic [LANES-1:0]  y_vec;
  logic              bit_s;
  logic [LANES-1:0]  hold_full;
  logic [LANES-1:0]  hold_perr;
  logic [DATA_W-1:0] hold_data [LANES];
  logic [LANES-1:0]  drain;
  lane_idx_t         last;
  lane_idx_t         grant;
  lane_idx_t         cand;
  logic              found;
  logic              load_out;

  assign y_vec = {y3, y2, y1, y0};
  assign bit_s = y_vec[sel];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    demux_deser_lane #(
      .DATA_W(DATA_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .shift_en  (bit_vld && (sel == lane_idx_t'(i))),
      .bit_in    (bit_s),
      .drain     (drain[i]),
      .ovf_clr   (ovf_clr),
      .hold_full (hold_full[i]),
      .hold_data (hold_data[i]),
      .hold_perr (hold_perr[i]),
      .ovf       (ovf[i])
    );
  end

  // Search starts one past the last grant; k=LANES wraps back to last itself.
  always_comb begin
    grant = last;
    found = 1'b0;
    cand  = last;
    for (int k = 1; k <= LANES; k++) begin
      cand = last + lane_idx_t'(k);
      if (!found && hold_full[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign load_out = !out_vld || out_rdy;
  assign drain    = (load_out && found) ? (LANES'(1) << grant) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_lane <= '0;
      out_perr <= 1'b0;
      out_vld  <= 1'b0;
      last     <= lane_idx_t'(LANES - 1);
    end else if (load_out) begin
      out_vld <= found;
      if (found) begin
        out_data <= hold_data[grant];
        out_lane <= grant;
        out_perr <= hold_perr[grant];
        last     <= grant;
      end
    end
  end

endmodule

// File: tb/tb_demux_lane_deserializer.sv
// tb/tb_demux_lane_deserializer.sv - self-checking bench: vector table, directed corner cases, random vs model
// Honours DEMUX_DESER_PARITY_EN when defined for the build.
module tb_demux_lane_deserializer;

  localparam int DATA_W = 8;
`ifdef DEMUX_DESER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FB = DATA_W + PAR;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              bit_vld = 1'b0;
  logic [1:0]        sel = '0;
  logic [3:0]        ys = '0;
  logic              clr = 1'b0;
  logic              out_rdy = 1'b0;
  logic              ovf_clr = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_lane;
  logic              out_perr;
  logic              out_vld;
  logic [3:0]        ovf;

  always #5 clk = ~clk;

  demux_lane_deserializer #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_vld  (bit_vld),
    .sel      (sel),
    .y0       (ys[0]),
    .y1       (ys[1]),
    .y2       (ys[2]),
    .y3       (ys[3]),
    .clr      (clr),
    .out_data (out_data),
    .out_lane (out_lane),
    .out_perr (out_perr),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Reference model: each lane is a bit list with a one-deep frame slot.
  int       m_cnt  [4];
  int       m_bits [4];
  bit       m_hv   [4];
  int       m_hd   [4];
  bit       m_hp   [4];
  bit       m_ov;
  int       m_od;
  int       m_ol;
  bit       m_op;
  int       m_last;
  bit [3:0] m_ovf;

  typedef struct {
    int lane;
    int data;
    int c;
  } obs_t;
  obs_t obs[$];
  int   cyc = 0;

  function automatic void model_reset();
    for (int l = 0; l < 4; l++) begin
      m_cnt[l] = 0; m_bits[l] = 0; m_hv[l] = 0; m_hd[l] = 0; m_hp[l] = 0;
    end
    m_ov = 0; m_od = 0; m_ol = 0; m_op = 0; m_last = 3; m_ovf = '0;
  endfunction

  function automatic void model_step();
    int g;
    int f;
    int l;
    bit [3:0] set;
    g = -1;
    set = '0;
    if (!m_ov || out_rdy) begin
      for (int k = 1; k <= 4; k++)
        if (g < 0 && m_hv[(m_last + k) % 4]) g = (m_last + k) % 4;
      if (g >= 0) begin
        m_ov = 1; m_od = m_hd[g]; m_ol = g; m_op = m_hp[g]; m_last = g; m_hv[g] = 0;
      end else begin
        m_ov = 0;
      end
    end
    if (clr) begin
      for (int j = 0; j < 4; j++) begin
        m_cnt[j] = 0; m_bits[j] = 0;
      end
    end else if (bit_vld) begin
      l = int'(sel);
      m_bits[l] = ((m_bits[l] << 1) | int'(ys[sel])) & ((1 << FB) - 1);
      m_cnt[l]++;
      if (m_cnt[l] == FB) begin
        f = m_bits[l];
        m_cnt[l] = 0;
        m_bits[l] = 0;
        if (m_hv[l]) set[l] = 1'b1;
        else begin
          m_hv[l] = 1;
          m_hd[l] = (PAR != 0) ? (f >> 1) : f;
          m_hp[l] = (PAR != 0) ? bit'($countones(f) % 2) : 1'b0;
        end
      end
    end
    if (ovf_clr) m_ovf = '0;
    else m_ovf = m_ovf | set;
  endfunction

  task automatic tick();
    if (out_vld && out_rdy) obs.push_back('{int'(out_lane), int'(out_data), cyc});
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bit_vld = 1'b0; clr = 1'b0; ovf_clr = 1'b0; out_rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_bit(input int lane, input logic b);
    sel = 2'(lane);
    ys = 4'($urandom);
    ys[lane] = b;
    bit_vld = 1'b1;
    tick();
    bit_vld = 1'b0;
  endtask

  task automatic send_raw(input int lane, input logic [DATA_W-1:0] data, input logic pbit);
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(lane, data[i]);
    if (PAR != 0) send_bit(lane, pbit);
  endtask

  task automatic send_frame(input int lane, input logic [DATA_W-1:0] data);
    send_raw(lane, data, ^data);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  typedef struct {
    int lane;
    int data;
    int exp_lane;
    int exp_data;
  } vec_t;
  vec_t vecs[5];

  int vals[4];
  int fw[4];

  initial begin
    vecs[0] = '{0, 'h00, 0, 'h00};
    vecs[1] = '{1, 'hFF, 1, 'hFF};
    vecs[2] = '{3, 'h81, 3, 'h81};
    vecs[3] = '{2, 'h5A, 2, 'h5A};
    vecs[4] = '{0, 'h7E, 0, 'h7E};
    vals = '{'h11, 'h22, 'h33, 'h44};

    do_reset();
    check("rst_out_vld", out_vld, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_lane", out_lane, 0);
    check("rst_out_perr", out_perr, 0);
    check("rst_ovf", ovf, 0);

    // 0xA5 on lane 2: visible exactly one edge after the last bit
    out_rdy = 1'b1;
    send_frame(2, 8'hA5);
    check("a5_not_yet", out_vld, 0);
    tick();
    check("a5_vld", out_vld, 1);
    check("a5_data", out_data, 'hA5);
    check("a5_lane", out_lane, 2);
    check("a5_perr", out_perr, 0);
    tick();
    check("a5_one_cycle", out_vld, 0);

    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].lane, 8'(vecs[i].data));
      tick();
      check($sformatf("vec%0d_vld", i), out_vld, 1);
      check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
      check($sformatf("vec%0d_lane", i), out_lane, vecs[i].exp_lane);
      tick();
    end

    // Interleaved lanes completing on consecutive edges
    obs.delete();
    for (int l = 0; l < 4; l++) fw[l] = (PAR != 0) ? ((vals[l] << 1) | ($countones(vals[l]) % 2)) : vals[l];
    for (int j = 0; j < FB; j++)
      for (int l = 0; l < 4; l++) send_bit(l, logic'((fw[l] >> (FB - 1 - j)) & 1));
    idle(5);
    check("il_count", obs.size(), 4);
    if (obs.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("il_lane%0d", i), obs[i].lane, i);
        check($sformatf("il_data%0d", i), obs[i].data, vals[i]);
        check($sformatf("il_cycle%0d", i), obs[i].c, obs[0].c + i);
      end
    end

    // Overflow on lane 1 while stalled
    out_rdy = 1'b0;
    send_frame(1, 8'h0F);
    send_frame(1, 8'hF0);
    send_frame(1, 8'h55);
    check("ovf_set", ovf, 4'b0010);
    check("ovf_vld", out_vld, 1);
    check("ovf_head", out_data, 'h0F);
    obs.delete();
    out_rdy = 1'b1;
    idle(4);
    check("ovf_count", obs.size(), 2);
    if (obs.size() == 2) begin
      check("ovf_first", obs[0].data, 'h0F);
      check("ovf_second", obs[1].data, 'hF0);
    end
    check("ovf_sticky", ovf, 4'b0010);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", ovf, 0);

    // clr drops a partial frame, and wins over a simultaneous bit
    obs.delete();
    repeat (4) send_bit(3, 1'b1);
    clr = 1'b1; sel = 2'd3; ys = 4'hF; bit_vld = 1'b1;
    tick();
    clr = 1'b0; bit_vld = 1'b0;
    send_frame(3, 8'hC3);
    idle(3);
    check("clr_count", obs.size(), 1);
    if (obs.size() == 1) begin
      check("clr_data", obs[0].data, 'hC3);
      check("clr_lane", obs[0].lane, 3);
    end

`ifdef DEMUX_DESER_PARITY_EN
    send_raw(0, 8'h07, 1'b1);
    tick();
    check("par_ok_vld", out_vld, 1);
    check("par_ok_perr", out_perr, 0);
    tick();
    send_raw(0, 8'h07, 1'b0);
    tick();
    check("par_bad_vld", out_vld, 1);
    check("par_bad_perr", out_perr, 1);
    check("par_bad_data", out_data, 'h07);
    tick();
`endif

    // Asynchronous reset mid-handshake with a partial frame pending
    out_rdy = 1'b0;
    send_frame(0, 8'h3C);
    tick();
    check("ar_pre_vld", out_vld, 1);
    repeat (3) send_bit(1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_vld_async", out_vld, 0);
    check("ar_data_async", out_data, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_rdy = 1'b1;
    send_frame(1, 8'h9A);
    tick();
    check("ar_post_vld", out_vld, 1);
    check("ar_post_data", out_data, 'h9A);
    check("ar_post_lane", out_lane, 1);
    tick();

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      bit_vld = ($urandom_range(0, 3) != 0);
      sel     = 2'($urandom);
      ys      = 4'($urandom);
      out_rdy = ((i / 60) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      clr     = ($urandom_range(0, 59) == 0);
      ovf_clr = ($urandom_range(0, 79) == 0);
      tick();
      check("rnd_vld", out_vld, m_ov);
      if (m_ov) begin
        check("rnd_data", out_data, m_od);
        check("rnd_lane", out_lane, m_ol);
        check("rnd_perr", out_perr, m_op);
      end
      check("rnd_ovf", ovf, m_ovf);
    end
    bit_vld = 1'b0; clr = 1'b0; ovf_clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_lane_deserializer.md
# demux_lane_deserializer

Downstream consumer of the 1-to-4 demux stage. It samples the four demux lane outputs each qualified cycle, assembles each lane's serial bits MSB-first into DATA_W-bit frames, and buffers one completed frame per lane. A round-robin arbiter merges the buffered frames onto a single valid/ready output port.

## Interface
- DATA_W, 8, data bits per frame (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- bit_vld  in  1  current lane bit is valid this cycle
- sel  in  2  lane select {s1,s0}, same value driven to the demux
- y0, y1, y2, y3  in  1 each  demux lane outputs
- clr  in  1  synchronous clear of all partial frames and bit counters
- out_data  out  DATA_W  completed frame
- out_lane  out  2  source lane of out_data
- out_perr  out  1  parity error flag for out_data
- out_vld  out  1  output frame valid
- out_rdy  in  1  consumer accepts frame
- ovf  out  4  sticky per-lane overflow flags
- ovf_clr  in  1  synchronous clear of all ovf bits

## Operation
- Sampled bit = y[sel]; on a clk edge with bit_vld=1, it shifts into lane sel's shift register (LSB in, so first bit ends up MSB) and that lane's bit counter increments. Other lanes are untouched.
- Frame completion: the edge that shifts in bit DATA_W (DATA_W+1 with parity) loads the frame into that lane's hold register, sets hold_full, and zeroes the counter.
- If hold_full is already set and is not drained on the same edge, the new frame is dropped and ovf[lane] is set. A drain and a completion on the same edge are legal: the new frame is accepted and no overflow is flagged.
- Output register: loads when empty, or on the same edge as a transfer (out_vld && out_rdy). It loads from the first full hold found in round-robin order, starting from the lane after the last granted lane. That hold's hold_full clears.
- clr: zeroes all shift registers and counters. Holds, the output register, and ovf are kept. clr has priority over a simultaneous bit_vld.
- ovf_clr has priority over a simultaneous overflow set.
- Reset values: out_data=0, out_lane=0, out_perr=0, out_vld=0, ovf=0. All counters and holds are empty, and the last-granted pointer is 3, so lane 0 is first.

## Timing
- Last bit edge → hold_full set. If the output register is empty, out_vld rises on the next edge: 1 cycle of latency from hold to output.
- Throughput: one frame per cycle while out_rdy=1 and holds are full.
- out_data, out_lane and out_perr are stable while out_vld=1 and out_rdy=0.
- rst_n assertion mid-frame or mid-handshake immediately discards all state. out_vld drops asynchronously.

## Configuration
- DEMUX_DESER_PARITY_EN defined:
  - Each frame is DATA_W+1 bits; the final bit is a parity bit.
  - Even parity is checked over data plus parity bit.
  - out_perr=1 on mismatch, travelling with the frame.
  - Only the DATA_W data bits go to out_data.
- DEMUX_DESER_PARITY_EN undefined:
  - Frames are DATA_W bits.
  - out_perr is tied to 0; the port is retained.

## Structure
- Package demux_deser_pkg holds:
  - LANES=4 and a 2-bit lane_idx_t typedef.
  - FRAME_BITS, computed as DATA_W or DATA_W+1 depending on the macro.
- Sub-module demux_deser_lane, instantiated four times, contains the shift register, bit counter, hold register, hold_full, overflow detect, and parity check.
- The top level holds the bit steering, the round-robin arbiter and the output register.

## Test plan
- Reset, then feed 8 bits of 0xA5 on lane 2 with out_rdy=1 → out_data=0xA5, out_lane=2, out_vld high one cycle, 1 cycle after the last bit.
- Interleave bits of 0x11/0x22/0x33/0x44 across lanes 0–3 so all complete on consecutive cycles, with out_rdy=1 → four outputs in order 0,1,2,3 on consecutive cycles.
- Hold out_rdy=0. Complete two frames on lane 1 (0x0F then 0xF0), then a third (0x55) → ovf[1]=1, out_data=0x0F. After release, 0xF0 follows and 0x55 is lost. ovf_clr clears ovf.
- Feed 4 bits on lane 3, pulse clr, then 8 bits of 0xC3 → output 0xC3, with no stale bits.
- With DEMUX_DESER_PARITY_EN, send 0x07 with parity bit 1 → out_perr=0. Send 0x07 with parity bit 0 → out_perr=1.
- Assert rst_n low while out_vld=1 and a partial frame is pending → out_vld=0 immediately. After release, the next full frame is correct.
